// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// for the shared datapath and counts retired instructions.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       opcode_reg,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             alu_force_add,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             illegal_instr,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMREAD = 4'd3,
    MEMWB    = 4'd4,  MEMWRITE = 4'd5, EXECUTE = 4'd6, ALUWB  = 4'd7,
    BRANCH   = 4'd8,  IEXEC   = 4'd9,  IWB    = 4'd10, JUMP    = 4'd11,
    HALT     = 4'd12
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       force_add;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       fetch;
    logic       branch;
    logic       bne;
  } ctrl_t;

  state_t             state_r;
  state_t             next_s;
  ctrl_t              ctrl_r;
  logic               illegal_r;
  logic [CNT_W-1:0]   count_r;
  logic               retire_s;
  logic               go_s;

  // Moore control word for a state; opcode only refines BRANCH and JUMP.
  function automatic ctrl_t decode(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.fetch = 1'b1; c.alu_src_b = 2'b01; c.force_add = 1'b1; end
      DECODE:   begin c.alu_src_b = 2'b11; c.force_add = 1'b1; end
      MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.force_add = 1'b1; end
      MEMREAD:  begin c.mem_req = 1'b1; c.iord = 1'b1; end
      MEMWB:    begin c.reg_write = 1'b1; c.mem_to_reg = 2'b01; end
      MEMWRITE: begin c.mem_req = 1'b1; c.iord = 1'b1; c.mem_write = 1'b1; end
      EXECUTE:  begin c.alu_src_a = 1'b1; end
      ALUWB:    begin c.reg_write = 1'b1; c.reg_dst = 2'b01; end
      BRANCH:   begin
        c.alu_src_a = 1'b1; c.pc_src = 2'b01; c.branch = 1'b1; c.bne = (op == 6'h05);
      end
      IEXEC:    begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      IWB:      begin c.reg_write = 1'b1; end
      JUMP:     begin
        c.pc_write = 1'b1; c.pc_src = 2'b10;
        if (op == 6'h03) begin
          c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
        end else begin
          c.reg_write = 1'b0;
        end
      end
      default:  c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection.
  always_comb begin
    next_s = FETCH;
    case (state_r)
      FETCH:    next_s = (run && mem_ready) ? DECODE : FETCH;
      DECODE: begin
        case (opcode_reg)
          6'h00:                      next_s = EXECUTE;
          6'h23, 6'h2B:               next_s = MEMADR;
          6'h04, 6'h05:               next_s = BRANCH;
          6'h08, 6'h0C, 6'h0D, 6'h0F: next_s = IEXEC;
          6'h02, 6'h03:               next_s = JUMP;
          default:                    next_s = HALT;
        endcase
      end
      MEMADR:   next_s = (opcode_reg == 6'h2B) ? MEMWRITE : MEMREAD;
      MEMREAD:  next_s = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    next_s = FETCH;
      MEMWRITE: next_s = mem_ready ? FETCH : MEMWRITE;
      EXECUTE:  next_s = ALUWB;
      ALUWB:    next_s = FETCH;
      BRANCH:   next_s = FETCH;
      IEXEC:    next_s = IWB;
      IWB:      next_s = FETCH;
      JUMP:     next_s = FETCH;
      HALT:     next_s = HALT;
      default:  next_s = FETCH;
    endcase
  end

  // An instruction retires when a final state hands back to FETCH.
  always_comb begin
    retire_s = 1'b0;
    case (state_r)
      MEMWB, MEMWRITE, ALUWB, BRANCH, IWB, JUMP: retire_s = (next_s == FETCH);
      default:                                   retire_s = 1'b0;
    endcase
  end

  // State, registered control word, sticky illegal flag and retire counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= FETCH;
      ctrl_r    <= decode(FETCH, 6'h00);
      illegal_r <= 1'b0;
      count_r   <= '0;
    end else begin
      state_r   <= next_s;
      ctrl_r    <= decode(next_s, opcode_reg);
      illegal_r <= illegal_r | (next_s == HALT);
      if (retire_s) begin
        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Qualifiers that depend on this cycle's handshake and zero flag; reset masks all controls.
  assign go_s          = ctrl_r.fetch & run & mem_ready;
  assign mem_req       = reset & (ctrl_r.mem_req | (ctrl_r.fetch & run));
  assign IorD          = reset & ctrl_r.iord;
  assign MemWrite      = reset & ctrl_r.mem_write;
  assign IRWrite       = reset & go_s;
  assign PCWrite       = reset & (ctrl_r.pc_write | go_s | (ctrl_r.branch & (zero ^ ctrl_r.bne)));
  assign PCSrc         = {2{reset}} & ctrl_r.pc_src;
  assign ALUSrcA       = reset & ctrl_r.alu_src_a;
  assign ALUSrcB       = {2{reset}} & ctrl_r.alu_src_b;
  assign alu_force_add = reset & ctrl_r.force_add;
  assign RegWrite      = reset & ctrl_r.reg_write;
  assign RegDst        = {2{reset}} & ctrl_r.reg_dst;
  assign MemtoReg      = {2{reset}} & ctrl_r.mem_to_reg;
  assign illegal_instr = illegal_r;
  assign state         = state_r;
  assign retired_count = count_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-cycle expected control words
// are queued as stimulus is driven and compared on the falling edge.
module tb_multicycle_control_fsm;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             run;
  logic [5:0]       opcode_reg;
  logic             zero;
  logic             mem_ready;
  logic             mem_req, IorD, MemWrite, IRWrite, PCWrite, ALUSrcA, alu_force_add;
  logic             RegWrite, illegal_instr;
  logic [1:0]       PCSrc, ALUSrcB, RegDst, MemtoReg;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired_count;

  typedef struct packed {
    logic [20:0]      ctrl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb_q[$];
  logic [CNT_W-1:0] cnt_model = '0;
  int               n_checks = 0;
  int               n_fail = 0;
  logic [20:0]      obs_ctrl;

  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode_reg(opcode_reg), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .alu_force_add(alu_force_add), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .illegal_instr(illegal_instr),
    .state(state), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  assign obs_ctrl = {state, mem_req, IorD, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA,
                     ALUSrcB, alu_force_add, RegWrite, RegDst, MemtoReg, illegal_instr};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected control word for a state under the given inputs.
  function automatic logic [20:0] ctrl_of(input logic [3:0] st, input logic r, input logic mr,
                                          input logic [5:0] op, input logic z);
    logic mreq, iord, mw, irw, pcw, asa, fa, rw, ill;
    logic [1:0] pcs, asb, rd, m2r;
    {mreq, iord, mw, irw, pcw, asa, fa, rw, ill} = 9'b0;
    {pcs, asb, rd, m2r} = 8'b0;
    case (st)
      4'd0:  begin mreq = r; asb = 2'b01; fa = 1'b1; irw = r & mr; pcw = r & mr; end
      4'd1:  begin asb = 2'b11; fa = 1'b1; end
      4'd2:  begin asa = 1'b1; asb = 2'b10; fa = 1'b1; end
      4'd3:  begin mreq = 1'b1; iord = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 2'b01; end
      4'd5:  begin mreq = 1'b1; iord = 1'b1; mw = 1'b1; end
      4'd6:  asa = 1'b1;
      4'd7:  begin rw = 1'b1; rd = 2'b01; end
      4'd8:  begin asa = 1'b1; pcs = 2'b01; pcw = (op == 6'h04) ? z : ~z; end
      4'd9:  begin asa = 1'b1; asb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin
        pcw = 1'b1; pcs = 2'b10;
        if (op == 6'h03) begin rw = 1'b1; rd = 2'b10; m2r = 2'b10; end
      end
      4'd12: ill = 1'b1;
      default: ill = 1'b0;
    endcase
    return {st, mreq, iord, mw, irw, pcw, pcs, asa, asb, fa, rw, rd, m2r, ill};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show during it.
  task automatic step(input logic [3:0] st, input logic r, input logic mr, input logic z);
    run = r; mem_ready = mr; zero = z;
    sb_q.push_back('{ctrl: ctrl_of(st, r, mr, opcode_reg, z), cnt: cnt_model});
    @(posedge clk); #1;
  endtask

  task automatic exec(input logic [5:0] op, input logic z, input int stall, input int fstall);
    logic r;
    opcode_reg = 6'($urandom);
    for (int i = 0; i < fstall; i++) begin
      r = rnd();
      step(4'd0, r, r ? 1'b0 : rnd(), rnd());
    end
    step(4'd0, 1'b1, 1'b1, rnd());
    opcode_reg = op;
    step(4'd1, rnd(), rnd(), rnd());
    case (op)
      6'h00: begin step(4'd6, rnd(), rnd(), rnd()); step(4'd7, rnd(), rnd(), rnd()); end
      6'h23: begin
        step(4'd2, rnd(), rnd(), rnd());
        for (int i = 0; i < stall; i++) step(4'd3, rnd(), 1'b0, rnd());
        step(4'd3, rnd(), 1'b1, rnd());
        step(4'd4, rnd(), rnd(), rnd());
      end
      6'h2B: begin
        step(4'd2, rnd(), rnd(), rnd());
        for (int i = 0; i < stall; i++) step(4'd5, rnd(), 1'b0, rnd());
        step(4'd5, rnd(), 1'b1, rnd());
      end
      6'h04, 6'h05: step(4'd8, rnd(), rnd(), z);
      6'h08, 6'h0C, 6'h0D, 6'h0F: begin
        step(4'd9, rnd(), rnd(), rnd()); step(4'd10, rnd(), rnd(), rnd());
      end
      6'h02, 6'h03: step(4'd11, rnd(), rnd(), rnd());
      default: begin
        for (int i = 0; i < 4; i++) step(4'd12, 1'(i & 1), rnd(), rnd());
        return;
      end
    endcase
    cnt_model = cnt_model + 1'b1;
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq("ctrl", 32'(obs_ctrl), 32'(e.ctrl));
      check_eq("count", 32'(retired_count), 32'(e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops [12];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h02, 6'h03, 6'h00};
    reset = 1'b0; run = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode_reg = 6'h00;
    #13;
    check_eq("rst_ctrl", 32'(obs_ctrl), 32'h0);
    check_eq("rst_cnt", 32'(retired_count), 32'h0);
    run = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    step(4'd0, 1'b0, 1'b1, 1'b0);
    step(4'd0, 1'b1, 1'b0, 1'b0);
    exec(6'h00, 1'b0, 0, 0);
    exec(6'h23, 1'b0, 2, 0);
    exec(6'h2B, 1'b0, 1, 1);
    exec(6'h04, 1'b1, 0, 0);
    exec(6'h04, 1'b0, 0, 0);
    exec(6'h05, 1'b0, 0, 0);
    exec(6'h05, 1'b1, 0, 2);
    exec(6'h08, 1'b0, 0, 0);
    exec(6'h0C, 1'b0, 0, 0);
    exec(6'h0D, 1'b0, 0, 0);
    exec(6'h0F, 1'b0, 0, 0);
    exec(6'h02, 1'b0, 0, 0);
    exec(6'h03, 1'b0, 0, 1);
    for (int i = 0; i < 10; i++)
      exec(ops[$urandom_range(0, 11)], rnd(), $urandom_range(0, 2), $urandom_range(0, 2));

    // Abort a store while it is waiting on memory.
    opcode_reg = 6'($urandom);
    step(4'd0, 1'b1, 1'b1, 1'b0);
    opcode_reg = 6'h2B;
    step(4'd1, 1'b1, 1'b1, 1'b0);
    step(4'd2, 1'b1, 1'b1, 1'b0);
    run = 1'b1; mem_ready = 1'b0;
    sb_q.push_back('{ctrl: ctrl_of(4'd5, 1'b1, 1'b0, opcode_reg, 1'b0), cnt: cnt_model});
    @(negedge clk); #1;
    reset = 1'b0; #1;
    check_eq("rst_memwrite", 32'(MemWrite), 32'h0);
    check_eq("rst_state", 32'(state), 32'h0);
    check_eq("rst_count", 32'(retired_count), 32'h0);
    check_eq("rst_ctrl2", 32'(obs_ctrl), 32'h0);
    cnt_model = '0; run = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    exec(6'h00, 1'b0, 0, 0);
    exec(6'h3F, 1'b0, 0, 0);
    reset = 1'b0; #1;
    check_eq("halt_clear", 32'(illegal_instr), 32'h0);
    check_eq("halt_state", 32'(state), 32'h0);
    run = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    cnt_model = '0;
    exec(6'h00, 1'b0, 0, 0);
    @(posedge clk); #1;
    check_eq("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
